// File: rtl/ct_stream_loader.sv
// Loads a length-prefixed ciphertext stream into the cracker's RAM, launches the cracker,
// and latches its key result and the crack duration.
module ct_stream_loader #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren,
    input  logic             crk_rdy,
    output logic             crk_en,
    input  logic [23:0]      crk_key,
    input  logic             crk_key_valid,
    output logic [23:0]      key,
    output logic             key_valid,
    output logic [CNT_W-1:0] crack_cycles,
    output logic             done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_DONE
    } state_t;

    state_t           state_q;
    logic [7:0]       len_q;
    logic [7:0]       idx_q;
    logic [7:0]       ct_addr_q;
    logic [7:0]       ct_wrdata_q;
    logic             ct_wren_q;
    logic             crk_en_q;
    logic [23:0]      key_q;
    logic             key_valid_q;
    logic [CNT_W-1:0] cycles_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
            crk_en_q    <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            ct_wren_q <= 1'b0;
            crk_en_q  <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ct_wren_q   <= 1'b1;
                        ct_addr_q   <= '0;
                        ct_wrdata_q <= in_data;
                        len_q       <= in_data;
                        idx_q       <= 8'd1;
                        state_q     <= (in_data == 8'd0) ? S_START : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        ct_wren_q   <= 1'b1;
                        ct_addr_q   <= idx_q;
                        ct_wrdata_q <= in_data;
                        idx_q       <= idx_q + 8'd1;
                        // idx never needs to pass 255: L=255 ends the load here
                        if (idx_q == len_q) state_q <= S_START;
                    end
                end
                S_START: begin
                    if (crk_rdy) begin
                        crk_en_q <= 1'b1;
                        cycles_q <= '0;
                        state_q  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
                    if (!crk_rdy) state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (crk_rdy) begin
                        key_q       <= crk_key;
                        key_valid_q <= crk_key_valid;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (cycles_q != '1) begin
                        cycles_q <= cycles_q + CNT_W'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign ct_addr      = ct_addr_q;
    assign ct_wrdata    = ct_wrdata_q;
    assign ct_wren      = ct_wren_q;
    assign crk_en       = crk_en_q;
    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign crack_cycles = cycles_q;
    assign done         = done_q;

endmodule
